// File: rtl/detect_pkg.sv
// Shared constants and types for the detector event-timestamp path.
package detect_pkg;
  localparam int DET_TS_W       = 16;
  localparam int DET_FIFO_DEPTH = 8;
  localparam int DET_DROP_W     = 8;

  typedef logic [DET_TS_W-1:0] det_ts_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head entry is visible whenever not empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;
  // Head is forced to zero when empty so the output is defined out of reset.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end
endmodule

// File: rtl/detect_event_fifo.sv
// Timestamps detector pulses with a free-running counter and queues them for a valid/ready reader.
module detect_event_fifo
  import detect_pkg::*;
#(
  parameter int TS_W   = DET_TS_W,
  parameter int DEPTH  = DET_FIFO_DEPTH,
  parameter int DROP_W = DET_DROP_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       detected,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TS_W-1:0]            out_ts,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count,
  input  logic                       clear_ovf
);
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              full, empty, pop, drop;

  always_comb begin
    ts_d = ts_q + TS_W'(1);
    pop  = ~empty & out_ready;
    drop = detected & full & ~pop;
    // Clear takes effect first so a coincident drop is still recorded.
    ovf_d  = clear_ovf ? 1'b0 : ovf_q;
    drop_d = clear_ovf ? '0 : drop_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_d != '1) begin
        drop_d = drop_d + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ts_q   <= ts_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (detected),
    .pop   (pop),
    .wdata (ts_q),
    .rdata (out_ts),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out_valid  = ~empty;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_detect_event_fifo.sv
// Bench for detect_event_fifo: queue-based reference model plus directed scenarios and random traffic.
module tb_detect_event_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        detected = 1'b0, out_ready = 1'b0, clear_ovf = 1'b0;
  logic        out_valid, overflow;
  logic [15:0] out_ts;
  logic [3:0]  level;
  logic [7:0]  drop_count;

  logic        w_det = 1'b0, w_rdy = 1'b0, w_clr = 1'b0;
  logic        w_valid, w_ovf;
  logic [3:0]  w_ts;
  logic [3:0]  w_level;
  logic [7:0]  w_drop;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  detect_event_fifo #(.TS_W(16), .DEPTH(8), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .detected(detected), .out_valid(out_valid),
    .out_ready(out_ready), .out_ts(out_ts), .level(level), .overflow(overflow),
    .drop_count(drop_count), .clear_ovf(clear_ovf)
  );

  detect_event_fifo #(.TS_W(4), .DEPTH(8), .DROP_W(8)) dut_w (
    .clk(clk), .rst(rst), .detected(w_det), .out_valid(w_valid),
    .out_ready(w_rdy), .out_ts(w_ts), .level(w_level), .overflow(w_ovf),
    .drop_count(w_drop), .clear_ovf(w_clr)
  );

  // Reference model: a plain queue of timestamps and counters.
  int unsigned m_q[$];
  logic [15:0] m_ts;
  logic        m_ovf;
  int          m_drop;
  bit          m_pop, m_full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_ts = 16'd0;
      m_ovf = 1'b0;
      m_drop = 0;
    end else begin
      m_pop  = (m_q.size() > 0) && out_ready;
      m_full = (m_q.size() == 8);
      if (m_pop) void'(m_q.pop_front());
      if (clear_ovf) begin
        m_ovf = 1'b0;
        m_drop = 0;
      end
      if (detected) begin
        if (!m_full || m_pop) m_q.push_back(int'(m_ts));
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      m_ts = m_ts + 16'd1;
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("cmp_valid", 32'(out_valid), 32'(m_q.size() != 0));
      check("cmp_level", 32'(level), 32'(m_q.size()));
      if (m_q.size() != 0) check("cmp_ts", 32'(out_ts), m_q[0]);
      check("cmp_ovf", 32'(overflow), 32'(m_ovf));
      check("cmp_drop", 32'(drop_count), 32'(m_drop));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ts(int v);
    int n = 0;
    while (m_ts != 16'(v) && n < 2000) begin
      tick();
      n++;
    end
    if (m_ts != 16'(v)) check("wait_ts_timeout", 32'(m_ts), 32'(v));
  endtask

  initial begin
    #1 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ts", 32'(out_ts), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_drop", 32'(drop_count), 0);

    // single event at ts=5, one-cycle latency
    wait_ts(5);
    detected = 1'b1; tick(); detected = 1'b0;
    check("single_valid", 32'(out_valid), 1);
    check("single_ts", 32'(out_ts), 5);
    check("single_level", 32'(level), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("single_pop_valid", 32'(out_valid), 0);
    check("single_pop_level", 32'(level), 0);

    // fill with 10,13..31 then overflow on a ninth event
    for (int i = 0; i < 8; i++) begin
      wait_ts(10 + 3 * i);
      detected = 1'b1; tick(); detected = 1'b0;
    end
    wait_ts(34);
    detected = 1'b1; tick(); detected = 1'b0;
    check("ovf_level", 32'(level), 8);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_drop", 32'(drop_count), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(out_valid), 1);
      check("drain_ts", 32'(out_ts), 32'(10 + 3 * i));
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 0);

    // full with simultaneous push and pop: nothing dropped, new entry at tail
    wait_ts(50);
    detected = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    out_ready = 1'b1; tick();
    detected = 1'b0;
    check("pp_level", 32'(level), 8);
    check("pp_drop", 32'(drop_count), 1);
    for (int i = 0; i < 8; i++) begin
      check("pp_drain_ts", 32'(out_ts), 32'(51 + i));
      tick();
    end
    out_ready = 1'b0;

    // drop counter saturation and clear-with-drop
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 0);
    check("clr_drop", 32'(drop_count), 0);
    wait_ts(100);
    detected = 1'b1;
    for (int i = 0; i < 8 + 300; i++) tick();
    check("sat_drop", 32'(drop_count), 255);
    check("sat_ovf", 32'(overflow), 1);
    clear_ovf = 1'b1; tick();
    check("clr_drop_same_ovf", 32'(overflow), 1);
    check("clr_drop_same_cnt", 32'(drop_count), 1);
    detected = 1'b0; tick(); clear_ovf = 1'b0;
    check("clr2_drop", 32'(drop_count), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("sat_drain_ts", 32'(out_ts), 32'(100 + i));
      tick();
    end
    out_ready = 1'b0;

    // asynchronous reset with level=5, pulses during reset discarded
    detected = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    detected = 1'b0;
    check("pre_rst_level", 32'(level), 5);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_level", 32'(level), 0);
    detected = 1'b1; tick(); tick(); detected = 1'b0;
    rst = 1'b0;
    check("post_rst_level", 32'(level), 0);
    detected = 1'b1; tick(); detected = 1'b0;
    check("post_rst_ts", 32'(out_ts), 0);
    check("post_rst_lvl1", 32'(level), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // timestamp wrap on the 4-bit instance: 15 then 0
    while (m_ts[3:0] != 4'd15) tick();
    w_det = 1'b1; tick(); tick(); w_det = 1'b0;
    check("wrap_valid", 32'(w_valid), 1);
    check("wrap_ts15", 32'(w_ts), 15);
    check("wrap_level", 32'(w_level), 2);
    w_rdy = 1'b1; tick();
    check("wrap_ts0", 32'(w_ts), 0);
    tick(); w_rdy = 1'b0;
    check("wrap_empty", 32'(w_valid), 0);

    // random traffic with one mid-run asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      detected  = ($urandom_range(99) < 45);
      out_ready = ($urandom_range(99) < 40);
      clear_ovf = ($urandom_range(99) < 3);
      if (i == 1500) begin
        #($urandom_range(5) + 1) rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    detected = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/detect_event_fifo.md
# detect_event_fifo

Timestamping event buffer directly downstream of the serial pattern detector. It samples the detector's one-cycle `detected` pulse, tags each event with a free-running cycle timestamp, and queues the timestamps in a small first-word-fall-through FIFO. A valid/ready consumer (CPU register block or logger) drains the FIFO. Overflow is reported through a sticky flag and a saturating drop counter.

## Interface
Parameters:
- `TS_W`, default 16: timestamp counter width; must be 4 or more.
- `DEPTH`, default 8: number of FIFO entries; must be a power of two and 2 or more.
- `DROP_W`, default 8: drop counter width; the counter saturates.

Ports (name, direction, width, meaning):
- `clk` input 1: the only clock; all state is updated on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `detected` input 1: event pulse from the upstream detector, sampled on every rising edge.
- `out_valid` output 1: the FIFO is not empty; `out_ts` holds the oldest entry.
- `out_ready` input 1: the consumer accepts the entry shown on `out_ts`.
- `out_ts` output TS_W: timestamp at the FIFO head.
- `level` output $clog2(DEPTH+1): current number of entries.
- `overflow` output 1: sticky flag; set when an event is dropped.
- `drop_count` output DROP_W: number of dropped events, saturating at all-ones.
- `clear_ovf` input 1: synchronous clear of `overflow` and `drop_count`.

## Operation
- Timestamp counter `ts`:
  - Reset value 0.
  - Increments by 1 every cycle and wraps from 2^TS_W−1 to 0.
- Push: at an edge where `detected`=1, the value written is `ts` as it was before that edge's increment.
- Pop: at an edge where `out_valid`=1 and `out_ready`=1. `out_ready` is ignored while `out_valid`=0.
- Push when not full: the entry is written and `level` increments, unless a pop happens in the same cycle, in which case `level` is unchanged.
- Push when full with a simultaneous pop: the push is accepted, `level` stays at DEPTH, and nothing is dropped.
- Push when full with no pop: the event is dropped. `overflow` is set to 1 and `drop_count` is incremented, saturating at 2^DROP_W−1. The FIFO contents are unchanged.
- Push when empty: only a push occurs, since a pop is impossible.
- `clear_ovf`=1 sets `overflow` to 0 and `drop_count` to 0 at the next edge. If a drop occurs in the same cycle, the drop is counted after the clear: `overflow`=1 and `drop_count`=1.
- Ordering is strict FIFO; entries are never reordered or overwritten.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from `level` (0 means empty, DEPTH means full).
- `out_ts` while `out_valid`=0 is don't-care. The bench must not check it.

## Timing
- Reset values:
  - `ts`=0, `level`=0, `out_valid`=0, `out_ts`=0.
  - `overflow`=0, `drop_count`=0.
  - Both pointers 0.
- Reset is asynchronous. Asserting `rst` mid-operation empties the FIFO immediately. Events pulsed while `rst`=1 are discarded.
- Latency: when `detected`=1 at edge N and the FIFO is empty, `out_valid`=1 and `out_ts` holds the entry after edge N. That is one cycle of latency.
- First-word fall-through: after a pop at edge M, the next entry is on `out_ts` after edge M with no bubble. `out_valid` drops after edge M only if `level` becomes 0.
- All outputs are registered or decoded from registered state. There is no combinational path from `detected` or `out_ready` to any output.
- Back-to-back `detected` pulses on consecutive cycles (not producible by a 110 detector, but legal) must each be queued with consecutive timestamps.

## Structure
- Shared package `detect_pkg` holds:
  - Default constants `DET_TS_W`=16, `DET_FIFO_DEPTH`=8, `DET_DROP_W`=8.
  - A `det_ts_t` typedef of TS_W bits.
- Sub-module `sync_fifo_fwft`, with parameters WIDTH and DEPTH:
  - Contains the storage array, the pointers, and `level`.
  - Ports: push, pop, wdata, rdata, full, empty, level.
- The top level keeps the timestamp counter, the drop/overflow logic and the handshake glue.

## Test plan
- Reset, then a single `detected` pulse at the edge where `ts`=5, `out_ready`=0 → `out_valid`=1 after that edge, `out_ts`=5, `level`=1. Raise `out_ready` → `out_valid`=0 and `level`=0 one edge later.
- 8 pulses at `ts`=10, 13, 16 … 31 with `out_ready`=0, then a 9th pulse → `level`=8, `overflow`=1, `drop_count`=1. Drain with `out_ready`=1 → the values 10, 13 … 31 come out in order on consecutive cycles.
- FIFO full, `detected`=1 and `out_ready`=1 in the same cycle → no drop, `level` stays 8, and the new timestamp appears at the tail.
- 300 drops while full with DROP_W=8 → `drop_count`=255 (saturated). `clear_ovf` pulsed in the same cycle as a further drop → `overflow`=1, `drop_count`=1.
- `ts` wrap with TS_W=4: a pulse at count 15 and the next at count 0 → `out_ts` reads 15 and then 0.
- Assert `rst` asynchronously, between clock edges, with `level`=5 → `out_valid`, `level` and `ts` go to 0 immediately. A pulse during reset is not queued.
